// File: rtl/btn_seq_matcher.sv
// btn_seq_matcher: per-button sync + debounce, press coding, and a
// sliding press-history matcher with chord reject, timeout and counter.
module btn_seq_matcher #(
    parameter int N_BTN      = 2,
    parameter int CODE_W     = 1,
    parameter int SEQ_LEN    = 5,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 0,
    parameter int OVERLAP    = 1,
    parameter int CNT_W      = 8,
    parameter logic [SEQ_LEN*CODE_W-1:0] PATTERN_RST = 5'b11011
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_BTN-1:0]              btn_raw,
    input  logic [SEQ_LEN*CODE_W-1:0]     pattern,
    input  logic                          pat_load,
    input  logic                          clr_cnt,
    output logic [N_BTN-1:0]              btn_db,
    output logic                          match,
    output logic [CNT_W-1:0]              match_cnt,
    output logic [$clog2(SEQ_LEN+1)-1:0]  fill
);

    localparam int PW = SEQ_LEN * CODE_W;
    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [N_BTN-1:0]  s1_q, s2_q;
    logic [N_BTN-1:0]  db_q, db_d, dly_q;
    logic [DW-1:0]     dcnt_q [N_BTN];
    logic [DW-1:0]     dcnt_d [N_BTN];

    logic [PW-1:0]     hist_q, hist_d, pat_q, pat_d, shifted;
    logic [FW-1:0]     fill_q, fill_d, fill_inc;
    logic [IW-1:0]     idle_q, idle_d;
    logic [CNT_W-1:0]  mcnt_q, mcnt_d;
    logic              match_q, match_d;

    logic [N_BTN-1:0]  rise;
    logic [CODE_W-1:0] code;
    logic              valid, chord, hit;

    // Debounce: flip the clean level after DEB_CYCLES differing samples
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_d[i] = dcnt_q[i];
            db_d[i]   = db_q[i];
            if (s2_q[i] == db_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                db_d[i]   = s2_q[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and delayed clean level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            dly_q <= '0;
            for (int i = 0; i < N_BTN; i++) dcnt_q[i] <= '0;
        end else begin
            s1_q  <= btn_raw;
            s2_q  <= s1_q;
            db_q  <= db_d;
            dly_q <= db_q;
            for (int i = 0; i < N_BTN; i++) dcnt_q[i] <= dcnt_d[i];
        end
    end

    // Press classification: lone rising edge is a press, anything else a chord
    always_comb begin
        rise  = db_q & ~dly_q;
        valid = (|rise)
              && ((rise & (rise - 1'b1)) == '0)
              && ((db_q & ~rise) == '0);
        chord = (|rise) && !valid;
        code  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (rise[i]) code = CODE_W'(i);
        end
        shifted  = (hist_q >> CODE_W)
                 | (PW'(code) << ((SEQ_LEN - 1) * CODE_W));
        fill_inc = (fill_q == FW'(SEQ_LEN)) ? fill_q : fill_q + 1'b1;
        hit      = (fill_inc == FW'(SEQ_LEN)) && (shifted == pat_q);
    end

    // History, fill, idle timer and match counter next state
    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        idle_d  = idle_q;
        match_d = 1'b0;
        mcnt_d  = mcnt_q;
        if (pat_load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
            idle_d = '0;
        end else if (chord) begin
            hist_d = '0;
            fill_d = '0;
            idle_d = '0;
        end else if (valid) begin
            hist_d  = shifted;
            fill_d  = fill_inc;
            idle_d  = '0;
            match_d = hit;
            if (hit && OVERLAP == 0) fill_d = '0;
        end else if (TIMEOUT > 0 && fill_q != '0) begin
            if (idle_q == IW'(TIMEOUT - 1)) begin
                fill_d = '0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
        if (clr_cnt) begin
            mcnt_d = match_d ? CNT_W'(1) : '0;
        end else if (match_d && mcnt_q != '1) begin
            mcnt_d = mcnt_q + 1'b1;
        end
    end

    // Matcher state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q  <= '0;
            pat_q   <= PATTERN_RST;
            fill_q  <= '0;
            idle_q  <= '0;
            match_q <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            idle_q  <= idle_d;
            match_q <= match_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign btn_db    = db_q;
    assign match     = match_q;
    assign match_cnt = mcnt_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_btn_seq_matcher.sv
// tb_btn_seq_matcher: two matcher instances (overlap+timeout, non-overlap)
// driven by directed and random press streams against a press-level model.
module tb_btn_seq_matcher;

    localparam int DEB = 4;
    localparam int TMO = 50;
    localparam int SEQ = 5;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] btn_raw;
    logic [4:0] pattern;
    logic       pat_load, clr_cnt;
    logic [1:0] db_o, db_n;
    logic       match_o, match_n;
    logic [7:0] mcnt_o, mcnt_n;
    logic [2:0] fill_o, fill_n;

    int cyc = 0;
    int pul_o = 0;
    int pul_n = 0;
    int n_tests = 0;
    int n_fail = 0;

    int q_o[$];
    int q_n[$];
    int mpat[SEQ];
    int cnt_o, cnt_n, last_p;
    int exp_pul_o = 0;
    int exp_pul_n = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (match_o === 1'b1) pul_o++;
        if (match_n === 1'b1) pul_n++;
    end

    btn_seq_matcher #(
        .N_BTN(2), .CODE_W(1), .SEQ_LEN(SEQ), .DEB_CYCLES(DEB),
        .TIMEOUT(TMO), .OVERLAP(1), .CNT_W(8), .PATTERN_RST(5'b11011)
    ) dut_o (
        .clk(clk), .rstn(rstn), .btn_raw(btn_raw), .pattern(pattern),
        .pat_load(pat_load), .clr_cnt(clr_cnt), .btn_db(db_o),
        .match(match_o), .match_cnt(mcnt_o), .fill(fill_o)
    );

    btn_seq_matcher #(
        .N_BTN(2), .CODE_W(1), .SEQ_LEN(SEQ), .DEB_CYCLES(DEB),
        .TIMEOUT(0), .OVERLAP(0), .CNT_W(8), .PATTERN_RST(5'b11011)
    ) dut_n (
        .clk(clk), .rstn(rstn), .btn_raw(btn_raw), .pattern(pattern),
        .pat_load(pat_load), .clr_cnt(clr_cnt), .btn_db(db_n),
        .match(match_n), .match_cnt(mcnt_n), .fill(fill_n)
    );

    // ---------------- press-level reference model ----------------
    function automatic bit seq_hit(input int q[$]);
        if (q.size() != SEQ) return 1'b0;
        for (int i = 0; i < SEQ; i++)
            if (q[i] != mpat[i]) return 1'b0;
        return 1'b1;
    endfunction

    // history of the timeout instance is dropped once TMO edges
    // have passed since its last accepted press (edge index upto)
    function automatic void m_timeout(input int upto);
        if (q_o.size() > 0 && last_p + TMO <= upto) q_o.delete();
    endfunction

    function automatic void m_press(input int b, input int rise_cyc);
        int p;
        p = rise_cyc + LAT;
        m_timeout(p - 1);
        last_p = p;
        if (q_o.size() == SEQ) void'(q_o.pop_front());
        q_o.push_back(b);
        if (seq_hit(q_o)) begin
            exp_pul_o++;
            if (cnt_o < 255) cnt_o++;
        end
        if (q_n.size() == SEQ) void'(q_n.pop_front());
        q_n.push_back(b);
        if (seq_hit(q_n)) begin
            exp_pul_n++;
            if (cnt_n < 255) cnt_n++;
            q_n.delete();
        end
    endfunction

    function automatic void m_load(input logic [4:0] p);
        for (int i = 0; i < SEQ; i++) mpat[i] = int'(p[i]);
        q_o.delete();
        q_n.delete();
    endfunction

    function automatic void m_reset();
        logic [4:0] d;
        d = 5'b11011;
        for (int i = 0; i < SEQ; i++) mpat[i] = int'(d[i]);
        q_o.delete();
        q_n.delete();
        cnt_o = 0;
        cnt_n = 0;
        last_p = 0;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        rstn = 1'b0;
        btn_raw = '0;
        pattern = '0;
        pat_load = 1'b0;
        clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold, input int gap);
        @(negedge clk);
        btn_raw[b] = 1'b1;
        m_press(b, cyc);
        repeat (hold) @(negedge clk);
        btn_raw[b] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chord(input int hold, input int gap);
        @(negedge clk);
        btn_raw = 2'b11;
        q_o.delete();
        q_n.delete();
        repeat (hold) @(negedge clk);
        btn_raw = 2'b00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic load(input logic [4:0] p);
        @(negedge clk);
        pattern = p;
        pat_load = 1'b1;
        @(negedge clk);
        pat_load = 1'b0;
        m_load(p);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        cnt_o = 0;
        cnt_n = 0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({db_o, db_n} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_db: got %b want 0000", {db_o, db_n});
        end
        n_tests++;
        if ({match_o, match_n} !== 2'b0) begin
            n_fail++;
            $display("FAIL rst_match: got %b want 00", {match_o, match_n});
        end
        n_tests++;
        if ({mcnt_o, mcnt_n} !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_cnt: got %0d/%0d want 0", mcnt_o, mcnt_n);
        end
        n_tests++;
        if ({fill_o, fill_n} !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_fill: got %0d/%0d want 0", fill_o, fill_n);
        end
    endtask

    task automatic test_debounce();
        logic e;
        do_reset();
        @(negedge clk);
        btn_raw[1] = 1'b1;
        m_press(1, cyc);
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            #1;
            e = (j >= 1 + 1 + DEB);
            n_tests++;
            if (db_o[1] !== e) begin
                n_fail++;
                $display("FAIL deb_lat edge+%0d: got %b want %b", j, db_o[1], e);
            end
        end
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                btn_raw[0] = (c < DEB - 1);
                n_tests++;
                if (db_o[0] !== 1'b0 || db_n[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL deb_glitch: got %b/%b want 0", db_o[0], db_n[0]);
                end
            end
        end
        btn_raw[1] = 1'b0;
        repeat (15) @(negedge clk);
        n_tests++;
        if (fill_o !== 3'd1 || fill_n !== 3'd1) begin
            n_fail++;
            $display("FAIL deb_fill: got %0d/%0d want 1", fill_o, fill_n);
        end
    endtask

    task automatic test_default_pattern();
        int p0, pn;
        do_reset();
        p0 = pul_o;
        pn = pul_n;
        press(1, 20, 20); press(1, 20, 20); press(0, 20, 20);
        press(1, 20, 20); press(1, 20, 20);
        n_tests++;
        if (pul_o - p0 !== 1 || mcnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL dflt_match: got %0d pulses cnt %0d want 1/1", pul_o - p0, mcnt_o);
        end
        n_tests++;
        if (fill_o !== 3'd5) begin
            n_fail++;
            $display("FAIL dflt_fill: got %0d want 5", fill_o);
        end
        n_tests++;
        if (pul_n - pn !== 1 || fill_n !== 3'd0) begin
            n_fail++;
            $display("FAIL dflt_noovl: got %0d pulses fill %0d want 1/0", pul_n - pn, fill_n);
        end
    endtask

    task automatic test_overlap();
        int p0, pn;
        int seq[8] = '{1, 1, 0, 1, 1, 0, 1, 1};
        do_reset();
        p0 = pul_o;
        pn = pul_n;
        foreach (seq[i]) press(seq[i], 12, 12);
        n_tests++;
        if (pul_o - p0 !== 2 || mcnt_o !== 8'd2) begin
            n_fail++;
            $display("FAIL ovl_on: got %0d pulses cnt %0d want 2/2", pul_o - p0, mcnt_o);
        end
        n_tests++;
        if (pul_n - pn !== 1 || mcnt_n !== 8'd1) begin
            n_fail++;
            $display("FAIL ovl_off: got %0d pulses cnt %0d want 1/1", pul_n - pn, mcnt_n);
        end
    endtask

    task automatic test_chord();
        int p0, pn;
        do_reset();
        p0 = pul_o;
        pn = pul_n;
        press(1, 12, 12);
        press(1, 12, 12);
        chord(15, 15);
        n_tests++;
        if (fill_o !== 3'd0 || fill_n !== 3'd0) begin
            n_fail++;
            $display("FAIL chord_fill: got %0d/%0d want 0", fill_o, fill_n);
        end
        press(0, 12, 12);
        press(1, 12, 12);
        press(1, 12, 12);
        n_tests++;
        if (fill_o !== 3'd3 || fill_n !== 3'd3) begin
            n_fail++;
            $display("FAIL chord_refill: got %0d/%0d want 3", fill_o, fill_n);
        end
        n_tests++;
        if (pul_o != p0 || pul_n != pn) begin
            n_fail++;
            $display("FAIL chord_nomatch: got %0d/%0d pulses want 0", pul_o - p0, pul_n - pn);
        end
    endtask

    task automatic test_timeout();
        int p0, pn;
        do_reset();
        p0 = pul_o;
        pn = pul_n;
        press(1, 15, 15); press(1, 15, 15);
        press(0, 15, 15); press(1, 15, 15);
        repeat (60) @(negedge clk);
        n_tests++;
        if (fill_o !== 3'd0 || fill_n !== 3'd4) begin
            n_fail++;
            $display("FAIL tmo_clear: got %0d/%0d want 0/4", fill_o, fill_n);
        end
        press(1, 15, 15);
        n_tests++;
        if (fill_o !== 3'd1 || pul_o != p0) begin
            n_fail++;
            $display("FAIL tmo_after: got fill %0d pulses %0d want 1/0", fill_o, pul_o - p0);
        end
        n_tests++;
        if (fill_n !== 3'd0 || pul_n - pn !== 1) begin
            n_fail++;
            $display("FAIL tmo_off: got fill %0d pulses %0d want 0/1", fill_n, pul_n - pn);
        end
    endtask

    task automatic test_pat_load();
        int p0, pn;
        do_reset();
        press(1, 12, 12);
        press(1, 12, 12);
        load(5'b00100);
        n_tests++;
        if (fill_o !== 3'd0 || fill_n !== 3'd0) begin
            n_fail++;
            $display("FAIL load_fill: got %0d/%0d want 0", fill_o, fill_n);
        end
        p0 = pul_o;
        pn = pul_n;
        press(0, 12, 12); press(0, 12, 12); press(1, 12, 12);
        press(0, 12, 12); press(0, 12, 12);
        n_tests++;
        if (pul_o - p0 !== 1 || pul_n - pn !== 1 || mcnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL load_match: got %0d/%0d pulses cnt %0d want 1/1/1",
                     pul_o - p0, pul_n - pn, mcnt_o);
        end
    endtask

    task automatic test_clr_cnt();
        int p0;
        p0 = pul_o;
        clear_cnt();
        n_tests++;
        if (mcnt_o !== 8'd0 || mcnt_n !== 8'd0 || pul_o != p0) begin
            n_fail++;
            $display("FAIL clr_cnt: got %0d/%0d want 0/0", mcnt_o, mcnt_n);
        end
    endtask

    task automatic test_saturate();
        int p0;
        do_reset();
        load(5'b11111);
        p0 = pul_o;
        for (int i = 0; i < 259; i++) press(1, 6, 8);
        n_tests++;
        if (mcnt_o !== 8'd255 || mcnt_n !== 8'd51) begin
            n_fail++;
            $display("FAIL sat_reach: got %0d/%0d want 255/51", mcnt_o, mcnt_n);
        end
        for (int i = 0; i < 3; i++) press(1, 6, 8);
        n_tests++;
        if (mcnt_o !== 8'd255 || mcnt_n !== 8'd52) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d/%0d want 255/52", mcnt_o, mcnt_n);
        end
        n_tests++;
        if (pul_o - p0 !== 258) begin
            n_fail++;
            $display("FAIL sat_pulses: got %0d want 258", pul_o - p0);
        end
    endtask

    task automatic test_reset_midpress();
        int p0;
        do_reset();
        load(5'b00000);
        press(1, 12, 12);
        press(1, 12, 12);
        @(negedge clk);
        btn_raw[1] = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({db_o, db_n, match_o, match_n, mcnt_o, mcnt_n, fill_o, fill_n} !== '0) begin
            n_fail++;
            $display("FAIL midrst_out: got fill %0d/%0d cnt %0d/%0d db %b/%b want 0",
                     fill_o, fill_n, mcnt_o, mcnt_n, db_o, db_n);
        end
        btn_raw = '0;
        @(negedge clk);
        rstn = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        p0 = pul_o;
        press(1, 10, 10); press(1, 10, 10); press(0, 10, 10);
        press(1, 10, 10); press(1, 10, 10);
        n_tests++;
        if (pul_o - p0 !== 1 || mcnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_pat: got %0d pulses cnt %0d want 1/1", pul_o - p0, mcnt_o);
        end
    endtask

    task automatic test_random();
        int r, b;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                chord($urandom_range(6, 20), $urandom_range(6, 30));
            end else if (r == 1) begin
                load(5'($urandom_range(0, 31)));
            end else if (r == 2) begin
                repeat ($urandom_range(40, 70)) @(negedge clk);
            end else if (r == 3) begin
                clear_cnt();
            end else begin
                if ($urandom_range(0, 2) != 0) b = mpat[q_o.size() % SEQ];
                else b = $urandom_range(0, 1);
                press(b, $urandom_range(6, 20), $urandom_range(6, 40));
            end
            m_timeout(cyc);
            n_tests++;
            if (fill_o !== 3'(q_o.size()) || fill_n !== 3'(q_n.size())) begin
                n_fail++;
                $display("FAIL rnd_fill it%0d: got %0d/%0d want %0d/%0d",
                         it, fill_o, fill_n, q_o.size(), q_n.size());
            end
            n_tests++;
            if (mcnt_o !== 8'(cnt_o) || mcnt_n !== 8'(cnt_n)) begin
                n_fail++;
                $display("FAIL rnd_cnt it%0d: got %0d/%0d want %0d/%0d",
                         it, mcnt_o, mcnt_n, cnt_o, cnt_n);
            end
            n_tests++;
            if (pul_o != exp_pul_o || pul_n != exp_pul_n) begin
                n_fail++;
                $display("FAIL rnd_pulses it%0d: got %0d/%0d want %0d/%0d",
                         it, pul_o, pul_n, exp_pul_o, exp_pul_n);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_default_pattern();
        test_overlap();
        test_chord();
        test_timeout();
        test_pat_load();
        test_clr_cnt();
        test_saturate();
        test_reset_midpress();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
